// File: rtl/divchain_sampler.sv
// divchain_sampler
// Divider chain (a binary up-counter whose bits serve as divided-clock taps)
// with a tap-selected sample-and-hold stage. The held sample is offered
// downstream through a valid/ack handshake.
//
// Optional feature macro: DIVCHAIN_OVERRUN_EN
//   defined   -> sticky overrun flag, set when a held sample is replaced
//                before it was acknowledged; cleared only by clr or reset.
//   undefined -> o_overrun is tied low and no overrun register exists.
//
// i_reset is asynchronous and active-low.
module divchain_sampler #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 1,
  parameter int SELW   = $clog2(STAGES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [SELW-1:0]   i_sel,
  input  logic [WIDTH-1:0]  i_din,
  input  logic              i_ack,
  output logic [STAGES-1:0] o_taps,
  output logic [WIDTH-1:0]  o_dout,
  output logic              o_valid,
  output logic              o_overrun
);

  logic [STAGES-1:0] r_taps;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid;

  logic [STAGES-1:0] w_taps_next;
  logic [SELW-1:0]   w_sel_eff;
  logic [STAGES-1:0] w_mask;
  logic              w_event;

  // Incrementing the whole chain is the same as the toggle rule: stage k
  // flips exactly when every lower stage becomes 0 after carrying.
  assign w_taps_next = r_taps + STAGES'(1);

  // Out-of-range selects fall back to the slowest tap. The compare is done
  // at 32 bits so STAGES = 2**SELW does not truncate the bound.
  assign w_sel_eff = (32'(i_sel) >= 32'(STAGES)) ? SELW'(STAGES - 1) : i_sel;

  // Mask covering bits [s:0] of the chain.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_mask[k] = (k <= int'(w_sel_eff));
    end
  end

  // An event fires on the edge that produces an all-ones tap prefix.
  assign w_event = i_en && ((w_taps_next & w_mask) == w_mask);

  // Chain advance, with clr returning it to the reset value.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_taps <= STAGES'(1);
    end else if (i_clr) begin
      r_taps <= STAGES'(1);
    end else if (i_en) begin
      r_taps <= w_taps_next;
    end
  end

  // Sample capture; clr leaves the held sample alone.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dout <= '0;
    end else if (!i_clr && w_event) begin
      r_dout <= i_din;
    end
  end

  // Handshake: a new sample always wins over a same-edge ack.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (w_event) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ack) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DIVCHAIN_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun: a held sample replaced without an ack on that edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overrun <= 1'b0;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else if (w_event && r_valid && !i_ack) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_taps  = r_taps;
  assign o_dout  = r_dout;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_divchain_sampler.sv
// Testbench for divchain_sampler (STAGES=5, WIDTH=8). Directed scenarios
// followed by randomized traffic, all compared against a count-based
// reference model. Honours DIVCHAIN_OVERRUN_EN the same way as the design.
module tb_divchain_sampler;

  localparam int STAGES = 5;
  localparam int WIDTH  = 8;
  localparam int SELW   = $clog2(STAGES);
  localparam int MODN   = 1 << STAGES;

`ifdef DIVCHAIN_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_en;
  logic              i_clr;
  logic [SELW-1:0]   i_sel;
  logic [WIDTH-1:0]  i_din;
  logic              i_ack;
  logic [STAGES-1:0] o_taps;
  logic [WIDTH-1:0]  o_dout;
  logic              o_valid;
  logic              o_overrun;

  divchain_sampler #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .i_sel     (i_sel),
    .i_din     (i_din),
    .i_ack     (i_ack),
    .o_taps    (o_taps),
    .o_dout    (o_dout),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: chain is just a count modulo 2^STAGES.
  int         m_cnt;
  logic [7:0] m_dout;
  bit         m_valid;
  bit         m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 1; m_dout = '0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input int sel,
                            input logic [7:0] din, input bit ack);
    int s, per, nxt;
    bit ev;
    if (clr) begin
      m_cnt = 1; m_valid = 0; m_ovr = 0;
    end else begin
      s   = (sel >= STAGES) ? STAGES - 1 : sel;
      per = 1 << (s + 1);
      nxt = en ? (m_cnt + 1) % MODN : m_cnt;
      ev  = en && ((nxt % per) == per - 1);
      if (ev) begin
        if (m_valid && !ack && OVR_EN) m_ovr = 1;
        m_dout  = din;
        m_valid = 1;
      end else if (m_valid && ack) begin
        m_valid = 0;
      end
      m_cnt = nxt;
    end
  endtask

  task automatic step(input bit en, input bit clr, input int sel,
                      input logic [7:0] din, input bit ack);
    i_en = en; i_clr = clr; i_sel = SELW'(sel); i_din = din; i_ack = ack;
    @(posedge i_clk);
    model_edge(en, clr, sel, din, ack);
    #1;
    check("taps",    32'(o_taps),    32'(m_cnt));
    check("dout",    32'(o_dout),    32'(m_dout));
    check("valid",   32'(o_valid),   32'(m_valid));
    check("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  // Counts edges (hold cycles with en=0 first, then en=1) until valid rises,
  // with ack held so a previous sample is released first.
  task automatic measure(input string tag, input int sel, input int hold,
                         input logic [7:0] din, input int exp);
    int n = 0;
    for (int i = 0; i < hold; i++) begin
      step(1'b0, 1'b0, sel, din, 1'b1);
      n++;
    end
    do begin
      step(1'b1, 1'b0, sel, din, 1'b1);
      n++;
    end while (!o_valid && n < 100);
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [7:0] held;
    i_reset = 1'b0; i_en = 0; i_clr = 0; i_sel = '0; i_din = '0; i_ack = 0;
    model_reset();
    #12;
    check("rst_taps",    32'(o_taps),    32'd1);
    check("rst_dout",    32'(o_dout),    32'd0);
    check("rst_valid",   32'(o_valid),   32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;   // idle edge, en=0

    // sel=4: first event after 30 edges, then every 32
    measure("first_evt_sel4", 4, 0, 8'hA5, 30);
    check("first_dout", 32'(o_dout), 32'hA5);
    measure("period_sel4", 4, 0, 8'h5A, 32);

    // sel=1: events at 3,7,11...; en=0 for 3 cycles stretches by 3
    step(1'b1, 1'b1, 1, 8'h00, 1'b0);
    measure("first_evt_sel1", 1, 0, 8'h01, 2);
    measure("period_sel1", 1, 0, 8'h02, 4);
    measure("stretch_sel1", 1, 3, 8'h03, 7);

    // overwrite without ack
    step(1'b1, 1'b1, 1, 8'h00, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1, 8'h11, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1, 8'h22, 1'b0);
    check("ovw_dout",    32'(o_dout),    32'h22);
    check("ovw_valid",   32'(o_valid),   32'd1);
    check("ovw_overrun", 32'(o_overrun), 32'(OVR_EN));
    step(1'b1, 1'b0, 1, 8'h00, 1'b1);
    check("ack_valid",   32'(o_valid),   32'd0);
    check("ack_overrun", 32'(o_overrun), 32'(OVR_EN));

    // ack on the same edge as an event while valid=1
    step(1'b1, 1'b1, 1, 8'h00, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1, 8'h77, 1'b0);
    step(1'b1, 1'b0, 1, 8'h3C, 1'b1);
    check("same_dout",    32'(o_dout),    32'h3C);
    check("same_valid",   32'(o_valid),   32'd1);
    check("same_overrun", 32'(o_overrun), 32'd0);

    // out-of-range select behaves as the top tap
    step(1'b1, 1'b1, 7, 8'h00, 1'b0);
    measure("sel7_as_sel4", 7, 0, 8'h66, 30);

    // clr mid-count keeps dout
    repeat (7) step(1'b1, 1'b0, 2, 8'h99, 1'b0);
    held = m_dout;
    step(1'b1, 1'b1, 2, 8'hEE, 1'b1);
    check("clr_taps",    32'(o_taps),    32'd1);
    check("clr_valid",   32'(o_valid),   32'd0);
    check("clr_overrun", 32'(o_overrun), 32'd0);
    check("clr_dout",    32'(o_dout),    32'(held));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 40) == 0),
           int'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset with valid=1 and taps=10110
    step(1'b1, 1'b1, 1, 8'h00, 1'b0);
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 1, 8'($urandom), 1'b0);
    check("pre_rst_taps",  32'(o_taps),  32'b10110);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    i_en = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    check("arst_taps",    32'(o_taps),    32'd1);
    check("arst_dout",    32'(o_dout),    32'd0);
    check("arst_valid",   32'(o_valid),   32'd0);
    check("arst_overrun", 32'(o_overrun), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (10) step(1'b1, 1'b0, 0, 8'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
